ol_rx_aligner_32: RTL and testbench
===================================

# ol_rx_aligner_32

Receive-side word aligner for the 32-bit optical link. It sits between the transceiver receive port and the data consumer, and runs in parallel with the link controller. It latches the half-word delay classification that the controller resolves at the end of link test, then re-frames every received 32-bit word. It emits aligned data with a valid strobe, tracks link health through a loss-of-sync detector, and keeps a saturating error counter.

## Interface
Parameters:
- LOS_LIMIT, 8: consecutive bad receive cycles in LOCKED that force loss of sync (range 1..255).
- ERR_W, 16: width of the error counter.

Ports:
- clk  in  1  link clock, single clock domain; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  32  raw received word from the transceiver.
- rx_datak  in  4  per-byte K flags for rx_data; bit i flags byte i.
- rx_valid  in  1  transceiver receive-enable; the word is usable when high.
- delay_mode  in  2  delay class from the controller: 0 in order, 1 half-word slip, 2 unresolved, 3 reserved.
- delay_load  in  1  one-cycle pulse; samples delay_mode (controller's test-to-data transition).
- data_out  out  32  aligned word; reset 0.
- data_valid  out  1  data_out is valid this cycle; reset 0.
- link_up  out  1  high in LOCKED; reset 0.
- los  out  1  one-cycle pulse on the LOCKED-to-IDLE loss of sync; reset 0.
- err_cnt  out  ERR_W  saturating count of bad cycles in LOCKED; reset 0.
- mode_q  out  2  latched delay_mode; reset 2.

## Operation
- States: IDLE, LOCKED, FAULT. Reset enters IDLE, sets mode_q=2, clears the bad-cycle run counter, and clears the prev-word register.
- IDLE: all outputs low except err_cnt. On delay_load, latch mode_q. Mode 0 or 1 goes to LOCKED. Mode 2 or 3 goes to FAULT.
- FAULT: link_up=0, data_valid=0. Leave only on delay_load, using the same rules as IDLE.
- LOCKED: link_up=1.
  - A cycle is bad when rx_valid=0 or rx_datak≠0.
  - The run counter increments on a bad cycle and clears on a good cycle.
  - When the run counter reaches LOS_LIMIT: pulse los, go to IDLE, clear the run counter.
  - err_cnt increments on every bad cycle in LOCKED and saturates at all-ones. Only reset clears it.
- delay_load while LOCKED re-latches mode_q and re-evaluates the state in the same cycle. Mode 2 or 3 goes to FAULT. Mode 0 or 1 stays in LOCKED.
- Framing, where prev = rx_data registered on every rx_valid cycle:
  - Mode 0: data_out = rx_data.
  - Mode 1: data_out = {prev[15:0], rx_data[31:16]}.
- data_valid is high only in LOCKED, on a good cycle. In mode 1 it additionally requires that prev was loaded by a good cycle.
- On a bad cycle, data_out holds its last value.

## Timing
- Latency: the rx word at edge t appears on data_out/data_valid after edge t+1 (one register stage).
- Mode 1: the first valid output after entering LOCKED comes one good cycle later than in mode 0 (prev is primed first).
- delay_load at edge t: state and mode_q update at t+1. Framing with the new mode applies from the word sampled at t+1.
- los is high exactly one cycle, coincident with link_up falling.
- Reset mid-operation: the next edge gives all outputs at reset values, including err_cnt=0.
- Simultaneous delay_load and LOS threshold in LOCKED: delay_load wins. The run counter clears and los is not pulsed.
- err_cnt saturation: at all-ones, further bad cycles leave it unchanged.

## Structure
- Shared package ol_pkg:
  - delay-mode encodings DLY_INORDER=0, DLY_SLIP=1, DLY_UNRES=2.
  - state enum IDLE/LOCKED/FAULT.
- One natural sub-module: ol_halfword_shifter, the combinational mux selecting the in-order or slipped word from rx_data and prev. The FSM, run counter and err_cnt live in the top.

## Test plan
- Mode 0 lock: reset, delay_load with mode 0, stream {n,n+1} for n=0..99 with rx_datak=0 → link_up=1; data_out={n,n+1} one cycle later with data_valid=1 throughout.
- Mode 1 slip: delay_load with mode 1, stream 32'h0003_0004 then 32'h0005_0006 → after the second word, data_out=32'h0004_0005, data_valid=1; the first word produces data_valid=0.
- Unresolved: delay_load with mode 2 → FAULT; link_up=0 and data_valid=0 for all inputs; a later delay_load with mode 0 → LOCKED.
- Loss of sync: in LOCKED, hold rx_datak=4'b0011 for 8 cycles → los pulses once on the 8th, link_up=0, err_cnt=8; 7 bad cycles followed by 1 good → no los.
- Saturation: ERR_W=4, 20 bad cycles with LOS_LIMIT=255 → err_cnt=15.
- Collision and reset: delay_load with mode 0 on the LOS-threshold cycle → no los, stays LOCKED; assert reset mid-stream → all outputs 0 and mode_q=2 next cycle.

Source files
------------

// File: rtl/ol_pkg.sv
// Shared definitions for the 32-bit optical link receive path:
// delay-mode encodings, the aligner state enum and a mode helper.
package ol_pkg;

    localparam logic [1:0] DLY_INORDER = 2'd0;
    localparam logic [1:0] DLY_SLIP    = 2'd1;
    localparam logic [1:0] DLY_UNRES   = 2'd2;
    localparam logic [1:0] DLY_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        FAULT  = 2'd2
    } olState_e;

    // True for the two delay classes the aligner can frame data with.
    function automatic logic isLockMode(input logic [1:0] mode);
        return (mode == DLY_INORDER) || (mode == DLY_SLIP);
    endfunction

endpackage

// File: rtl/ol_halfword_shifter.sv
// Combinational re-framing mux: passes the received word through
// unchanged, or splices the low half of the previous word onto the
// high half of the current one when the link slipped by a half word.
module ol_halfword_shifter
    import ol_pkg::*;
(
    input  logic [31:0] rx_data_i,
    input  logic [15:0] prev_low_i,
    input  logic [1:0]  mode_i,
    output logic [31:0] word_o
);

    // Select the in-order or half-word-slipped word.
    always_comb begin
        word_o = rx_data_i;
        if (mode_i == DLY_SLIP) begin
            word_o = {prev_low_i, rx_data_i[31:16]};
        end
    end

endmodule

// File: rtl/ol_rx_aligner_32.sv
// Receive-side word aligner. Latches the controller's delay class,
// re-frames each received word, flags valid output, detects loss of
// sync from runs of bad cycles and keeps a saturating error count.
module ol_rx_aligner_32
    import ol_pkg::*;
#(
    parameter int LOS_LIMIT = 8,
    parameter int ERR_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      rx_data,
    input  logic [3:0]       rx_datak,
    input  logic             rx_valid,
    input  logic [1:0]       delay_mode,
    input  logic             delay_load,
    output logic [31:0]      data_out,
    output logic             data_valid,
    output logic             link_up,
    output logic             los,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       mode_q
);

    localparam logic [7:0]       LOS_LIM = 8'(LOS_LIMIT);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    olState_e         state_q, state_d;
    logic [1:0]       mode_d;
    logic [7:0]       runCnt_q, runCnt_d;
    logic [ERR_W-1:0] errCnt_q, errCnt_d;
    logic [31:0]      prevWord_q, prevWord_d;
    logic             prevGood_q, prevGood_d;
    logic [31:0]      dataOut_q, dataOut_d;
    logic             dataValid_q, dataValid_d;
    logic             los_q, los_d;

    logic             isLocked;
    logic             badCycle;
    logic [31:0]      framedWord;

    assign isLocked = (state_q == LOCKED);
    assign badCycle = !rx_valid || (rx_datak != 4'd0);

    ol_halfword_shifter u_shifter (
        .rx_data_i  (rx_data),
        .prev_low_i (prevWord_q[15:0]),
        .mode_i     (mode_q),
        .word_o     (framedWord)
    );

    // Register all state; reset returns every output to its idle value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= DLY_UNRES;
            runCnt_q    <= '0;
            errCnt_q    <= '0;
            prevWord_q  <= '0;
            prevGood_q  <= 1'b0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
            los_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            runCnt_q    <= runCnt_d;
            errCnt_q    <= errCnt_d;
            prevWord_q  <= prevWord_d;
            prevGood_q  <= prevGood_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
            los_q       <= los_d;
        end
    end

    // Next-state logic: framing, run/error counting and state transitions.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        runCnt_d    = runCnt_q;
        errCnt_d    = errCnt_q;
        prevWord_d  = prevWord_q;
        prevGood_d  = prevGood_q;
        dataOut_d   = dataOut_q;
        dataValid_d = 1'b0;
        los_d       = 1'b0;

        // The previous word only counts as primed once a good word has
        // been captured while locked, so mode 1 always waits one word.
        if (!isLocked) begin
            prevGood_d = 1'b0;
        end else if (rx_valid) begin
            prevGood_d = !badCycle;
        end
        if (rx_valid) begin
            prevWord_d = rx_data;
        end

        unique case (state_q)
            IDLE, FAULT: begin
                dataOut_d = '0;
                runCnt_d  = '0;
                if (delay_load) begin
                    mode_d  = delay_mode;
                    state_d = isLockMode(delay_mode) ? LOCKED : FAULT;
                end
            end
            LOCKED: begin
                if (!badCycle) begin
                    dataOut_d   = framedWord;
                    dataValid_d = (mode_q == DLY_INORDER) || prevGood_q;
                end else if (errCnt_q != ERR_MAX) begin
                    errCnt_d = errCnt_q + ERR_W'(1);
                end

                if (delay_load) begin
                    mode_d   = delay_mode;
                    state_d  = isLockMode(delay_mode) ? LOCKED : FAULT;
                    runCnt_d = '0;
                end else if (badCycle) begin
                    if (runCnt_q + 8'd1 == LOS_LIM) begin
                        los_d    = 1'b1;
                        state_d  = IDLE;
                        runCnt_d = '0;
                    end else begin
                        runCnt_d = runCnt_q + 8'd1;
                    end
                end else begin
                    runCnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_out   = dataOut_q;
    assign data_valid = dataValid_q;
    assign link_up    = isLocked;
    assign los        = los_q;
    assign err_cnt    = errCnt_q;

endmodule

// File: tb/tb_ol_rx_aligner_32.sv
// Self-checking bench for ol_rx_aligner_32: directed steps plus a random
// phase, compared against a behavioural model of the aligner's rules.
module tb_ol_rx_aligner_32;

    localparam int M_IDLE   = 0;
    localparam int M_LOCKED = 1;
    localparam int M_FAULT  = 2;
    localparam int LIMIT    = 8;
    localparam int ERR_MAX  = 65535;

    logic        clk;
    logic        reset;
    logic [31:0] rxData;
    logic [3:0]  rxDatak;
    logic        rxValid;
    logic [1:0]  delayMode;
    logic        delayLoad;
    logic [31:0] dataOut;
    logic        dataValid;
    logic        linkUp;
    logic        los;
    logic [15:0] errCnt;
    logic [1:0]  modeQ;

    logic        sReset;
    logic [31:0] sRxData;
    logic [3:0]  sRxDatak;
    logic        sRxValid;
    logic [1:0]  sDelayMode;
    logic        sDelayLoad;
    logic [31:0] sDataOut;
    logic        sDataValid;
    logic        sLinkUp;
    logic        sLos;
    logic [3:0]  sErrCnt;
    logic [1:0]  sModeQ;

    int compared = 0;
    int mismatched = 0;

    int          mState;
    logic [1:0]  mMode;
    int          mRun;
    int          mErr;
    logic [31:0] mPrev;
    bit          mPrimed;
    logic [31:0] eDout;
    bit          eDv;
    bit          eLos;

    ol_rx_aligner_32 #(.LOS_LIMIT(LIMIT), .ERR_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rxData),
        .rx_datak   (rxDatak),
        .rx_valid   (rxValid),
        .delay_mode (delayMode),
        .delay_load (delayLoad),
        .data_out   (dataOut),
        .data_valid (dataValid),
        .link_up    (linkUp),
        .los        (los),
        .err_cnt    (errCnt),
        .mode_q     (modeQ)
    );

    ol_rx_aligner_32 #(.LOS_LIMIT(255), .ERR_W(4)) dutSat (
        .clk        (clk),
        .reset      (sReset),
        .rx_data    (sRxData),
        .rx_datak   (sRxDatak),
        .rx_valid   (sRxValid),
        .delay_mode (sDelayMode),
        .delay_load (sDelayLoad),
        .data_out   (sDataOut),
        .data_valid (sDataValid),
        .link_up    (sLinkUp),
        .los        (sLos),
        .err_cnt    (sErrCnt),
        .mode_q     (sModeQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: outputs come from the state before the edge,
    // then the state advances following the link rules.
    task automatic modelStep(input bit rst, input bit valid, input logic [3:0] k,
                             input logic [31:0] d, input bit load, input logic [1:0] mode);
        bit bad;
        if (rst) begin
            mState = M_IDLE; mMode = 2'd2; mRun = 0; mErr = 0;
            mPrev = '0; mPrimed = 0; eDout = '0; eDv = 0; eLos = 0;
        end else begin
            bad  = !valid || (k != 4'd0);
            eDv  = 0;
            eLos = 0;
            if (mState == M_LOCKED) begin
                if (!bad) begin
                    if (mMode == 2'd1) begin
                        eDout = {mPrev[15:0], d[31:16]};
                        eDv   = mPrimed;
                    end else begin
                        eDout = d;
                        eDv   = 1;
                    end
                end else if (mErr < ERR_MAX) begin
                    mErr++;
                end
            end else begin
                eDout = '0;
            end
            if (mState != M_LOCKED) mPrimed = 0;
            else if (valid)         mPrimed = !bad;
            if (valid) mPrev = d;
            if (load) begin
                mMode  = mode;
                mState = (mode <= 2'd1) ? M_LOCKED : M_FAULT;
                mRun   = 0;
            end else if (mState == M_LOCKED) begin
                if (bad) begin
                    mRun++;
                    if (mRun >= LIMIT) begin
                        eLos   = 1;
                        mState = M_IDLE;
                        mRun   = 0;
                    end
                end else begin
                    mRun = 0;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("data_valid", {31'd0, dataValid}, {31'd0, eDv});
        checkOutput("link_up", {31'd0, linkUp}, {31'd0, mState == M_LOCKED});
        checkOutput("los", {31'd0, los}, {31'd0, eLos});
        checkOutput("err_cnt", {16'd0, errCnt}, 32'(mErr));
        checkOutput("mode_q", {30'd0, modeQ}, {30'd0, mMode});
        if (eDv) checkOutput("data_out", dataOut, eDout);
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic applyStimulus(input bit rst, input bit valid, input logic [3:0] k,
                                 input logic [31:0] d, input bit load, input logic [1:0] mode);
        reset     = rst;
        rxValid   = valid;
        rxDatak   = k;
        rxData    = d;
        delayLoad = load;
        delayMode = mode;
        modelStep(rst, valid, k, d, load, mode);
        @(posedge clk);
        #1;
        checkAll();
    endtask

    initial begin
        reset = 1'b1; rxValid = 1'b0; rxDatak = '0; rxData = '0;
        delayLoad = 1'b0; delayMode = '0;
        sReset = 1'b1; sRxValid = 1'b0; sRxDatak = '0; sRxData = '0;
        sDelayLoad = 1'b0; sDelayMode = '0;

        // Reset values
        applyStimulus(1, 0, 4'd0, 32'd0, 0, 2'd0);
        applyStimulus(1, 0, 4'd0, 32'd0, 0, 2'd0);
        checkOutput("reset_data_out", dataOut, 32'd0);
        checkOutput("reset_mode_q", {30'd0, modeQ}, 32'd2);

        // Mode 0 lock with a counting stream
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 2'd0);
        for (int n = 0; n < 100; n++) begin
            applyStimulus(0, 1, 4'd0, {16'(n), 16'(n + 1)}, 0, 2'd0);
        end

        // Mode 1 slip: first word primes, second word emits the splice
        applyStimulus(1, 0, 4'd0, 32'd0, 0, 2'd0);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 2'd1);
        applyStimulus(0, 1, 4'd0, 32'h0003_0004, 0, 2'd0);
        checkOutput("slip_first_valid", {31'd0, dataValid}, 32'd0);
        applyStimulus(0, 1, 4'd0, 32'h0005_0006, 0, 2'd0);
        checkOutput("slip_second_word", dataOut, 32'h0004_0005);

        // Unresolved mode parks in FAULT until a usable mode is loaded
        applyStimulus(0, 1, 4'd0, 32'h1111_2222, 1, 2'd2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 1)), $urandom, 0, 2'd0);
        end
        applyStimulus(0, 1, 4'd0, 32'h3333_4444, 1, 2'd3);
        applyStimulus(0, 1, 4'd0, 32'h5555_6666, 1, 2'd0);
        applyStimulus(0, 1, 4'd0, 32'h7777_8888, 0, 2'd0);

        // Loss of sync after LIMIT consecutive bad cycles
        applyStimulus(1, 0, 4'd0, 32'd0, 0, 2'd0);
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 2'd0);
        for (int i = 0; i < LIMIT; i++) begin
            applyStimulus(0, 1, 4'b0011, 32'hDEAD_0000 + 32'(i), 0, 2'd0);
        end
        checkOutput("los_pulse", {31'd0, los}, 32'd1);
        checkOutput("los_err_cnt", {16'd0, errCnt}, 32'd8);
        applyStimulus(0, 1, 4'd0, 32'h0, 0, 2'd0);

        // Seven bad then one good: the run resets without losing sync
        applyStimulus(0, 0, 4'd0, 32'd0, 1, 2'd0);
        for (int i = 0; i < LIMIT - 1; i++) begin
            applyStimulus(0, 0, 4'd0, 32'd0, 0, 2'd0);
        end
        applyStimulus(0, 1, 4'd0, 32'hABCD_0123, 0, 2'd0);
        for (int i = 0; i < LIMIT - 1; i++) begin
            applyStimulus(0, 1, 4'b0100, 32'd0, 0, 2'd0);
        end

        // Collision: delay_load on the threshold cycle wins over loss of sync
        applyStimulus(0, 1, 4'b0011, 32'd0, 1, 2'd0);
        checkOutput("collision_link_up", {31'd0, linkUp}, 32'd1);
        applyStimulus(0, 1, 4'd0, 32'h0BAD_F00D, 0, 2'd0);

        // Reset in the middle of a stream
        applyStimulus(0, 1, 4'd0, 32'h1234_5678, 0, 2'd0);
        applyStimulus(1, 1, 4'd0, 32'h9ABC_DEF0, 0, 2'd0);
        checkOutput("midreset_err_cnt", {16'd0, errCnt}, 32'd0);
        checkOutput("midreset_mode_q", {30'd0, modeQ}, 32'd2);

        // Random traffic with occasional reloads and resets
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'd0,
                          $urandom,
                          ($urandom_range(0, 29) == 0),
                          2'($urandom_range(0, 3)));
        end

        // Saturation on a narrow counter that never reaches its LOS limit
        sReset = 1'b1;
        @(posedge clk); #1;
        sReset = 1'b0; sDelayLoad = 1'b1; sDelayMode = 2'd0;
        @(posedge clk); #1;
        checkOutput("sat_link_up", {31'd0, sLinkUp}, 32'd1);
        sDelayLoad = 1'b0; sRxValid = 1'b1; sRxDatak = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            checkOutput("sat_err_cnt", {28'd0, sErrCnt}, (k > 15) ? 32'd15 : 32'(k));
        end
        checkOutput("sat_still_up", {31'd0, sLinkUp}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
